// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcode encodings and FSM states.
package alu_pkg;

    localparam int unsigned OPC_W = 5;

    localparam logic [OPC_W-1:0] OP_ADD = 5'd0;
    localparam logic [OPC_W-1:0] OP_SUB = 5'd1;
    localparam logic [OPC_W-1:0] OP_AND = 5'd2;
    localparam logic [OPC_W-1:0] OP_OR  = 5'd3;
    localparam logic [OPC_W-1:0] OP_SLL = 5'd4;
    localparam logic [OPC_W-1:0] OP_SRA = 5'd5;
    localparam logic [OPC_W-1:0] OP_MUL = 5'd6;
    localparam logic [OPC_W-1:0] OP_DIV = 5'd7;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } alu_state_t;

endpackage

// File: rtl/mul_div_iter.sv
// Iterative unsigned shift-add multiplier / restoring divider with sign fix-up.
// Ports:
//   clock, reset   : clock and asynchronous active-high reset
//   load_i         : capture magnitudes, op select and sign; counter <= WIDTH-1
//   step_i         : perform one iteration (asserted while the top is in ITER)
//   is_div_i       : 1 = divide, 0 = multiply
//   mag_a_i/mag_b_i: operand magnitudes (multiplicand/dividend, multiplier/divisor)
//   neg_i          : negate the final result (operand signs differ)
//   result_c       : low WIDTH bits of the signed result of the current step
//   prod_hi_c      : high WIDTH bits of the signed 2*WIDTH product (MUL only)
//   done_c         : counter has reached 0, the current step is the last one
module mul_div_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_i,
    input  logic             step_i,
    input  logic             is_div_i,
    input  logic [WIDTH-1:0] mag_a_i,
    input  logic [WIDTH-1:0] mag_b_i,
    input  logic             neg_i,
    output logic [WIDTH-1:0] result_c,
    output logic [WIDTH-1:0] prod_hi_c,
    output logic             done_c
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam int unsigned PW = 2 * WIDTH;

    logic [CW-1:0]    cnt_q;
    logic [PW-1:0]    p_q;
    logic [PW-1:0]    p_d;
    logic [WIDTH-1:0] b_mag_q;
    logic             is_div_q;
    logic             neg_q;
    logic [WIDTH:0]   sum_c;
    logic [WIDTH:0]   shifted_c;
    logic [WIDTH:0]   trial_c;
    logic [PW-1:0]    fixed_c;

    // One iteration. p_q holds {acc, a} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        sum_c     = {1'b0, p_q[PW-1:WIDTH]} + {1'b0, b_mag_q};
        shifted_c = {p_q[PW-1:WIDTH], p_q[WIDTH-1]};
        trial_c   = shifted_c - {1'b0, b_mag_q};
        p_d       = p_q;
        if (is_div_q) begin
            if (shifted_c >= {1'b0, b_mag_q}) begin
                p_d = {trial_c[WIDTH-1:0], p_q[WIDTH-2:0], 1'b1};
            end else begin
                p_d = {shifted_c[WIDTH-1:0], p_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (p_q[0]) begin
                p_d = {sum_c, p_q[WIDTH-1:1]};
            end else begin
                p_d = {1'b0, p_q[PW-1:WIDTH], p_q[WIDTH-1:1]};
            end
        end
    end

    // Negating the full 2*WIDTH value leaves the low half equal to the negated
    // quotient, so one negator serves both operations.
    always_comb begin
        fixed_c   = neg_q ? -p_d : p_d;
        result_c  = fixed_c[WIDTH-1:0];
        prod_hi_c = fixed_c[PW-1:WIDTH];
        done_c    = (cnt_q == '0);
    end

    // Iteration state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            p_q      <= '0;
            b_mag_q  <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
        end else if (load_i) begin
            cnt_q    <= CW'(WIDTH - 1);
            p_q      <= {{WIDTH{1'b0}}, mag_a_i};
            b_mag_q  <= mag_b_i;
            is_div_q <= is_div_i;
            neg_q    <= neg_i;
        end else if (step_i) begin
            p_q <= p_d;
            if (cnt_q != '0) begin
                cnt_q <= cnt_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ADD/SUB/AND/OR/SLL/SRA plus iterative signed MUL/DIV.
// Ports:
//   clock, reset        : clock and asynchronous active-high reset
//   ctrl_start          : begin an operation (ignored while busy)
//   ctrl_ALUopcode      : 0 ADD,1 SUB,2 AND,3 OR,4 SLL,5 SRA,6 MUL,7 DIV, others ADD
//   ctrl_shiftamt       : shift distance for SLL/SRA
//   data_operandA/B     : signed operands
//   data_result         : registered result, held until the next completion
//   isNotEqual/isLessThan: registered A!=B and signed A<B of the operation's operands
//   overflow            : registered signed-overflow flag
//   data_exception      : registered divide-by-zero flag
//   data_resultRDY      : one-cycle completion pulse
//   busy                : high while MUL/DIV iterates
module alu_mc
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_start,
    input  logic [4:0]       ctrl_ALUopcode,
    input  logic [SHW-1:0]   ctrl_shiftamt,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             isNotEqual,
    output logic             isLessThan,
    output logic             overflow,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    alu_state_t       state_q, state_d;
    logic [4:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             ne_q, ne_d;
    logic             lt_q, lt_d;
    logic             ovf_q, ovf_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
    logic             busy_q, busy_d;

    logic [WIDTH-1:0] sum_c, diff_c;
    logic [WIDTH-1:0] sc_result_c;
    logic             sc_ovf_c;
    logic             b_zero_c;
    logic             start_iter_c;
    logic             iter_load_c;
    logic             iter_step_c;
    logic [WIDTH-1:0] mag_a_c, mag_b_c;
    logic             neg_c;
    logic [WIDTH-1:0] iter_result_c;
    logic [WIDTH-1:0] iter_hi_c;
    logic             iter_done_c;
    logic             mul_ovf_c;
    logic             div_ovf_c;

    // Single-cycle datapath, evaluated on the live inputs at the start edge.
    always_comb begin
        sum_c       = data_operandA + data_operandB;
        diff_c      = data_operandA - data_operandB;
        sc_result_c = sum_c;
        sc_ovf_c    = (data_operandA[WIDTH-1] == data_operandB[WIDTH-1]) &&
                      (sum_c[WIDTH-1] != data_operandA[WIDTH-1]);
        case (ctrl_ALUopcode)
            OP_SUB: begin
                sc_result_c = diff_c;
                sc_ovf_c    = (data_operandA[WIDTH-1] != data_operandB[WIDTH-1]) &&
                              (diff_c[WIDTH-1] != data_operandA[WIDTH-1]);
            end
            OP_AND: begin
                sc_result_c = data_operandA & data_operandB;
                sc_ovf_c    = 1'b0;
            end
            OP_OR: begin
                sc_result_c = data_operandA | data_operandB;
                sc_ovf_c    = 1'b0;
            end
            OP_SLL: begin
                sc_result_c = data_operandA << ctrl_shiftamt;
                sc_ovf_c    = 1'b0;
            end
            OP_SRA: begin
                sc_result_c = WIDTH'($signed(data_operandA) >>> ctrl_shiftamt);
                sc_ovf_c    = 1'b0;
            end
            OP_MUL, OP_DIV: begin
                // Only DIV-by-zero completes here; it yields 0 without overflow.
                sc_result_c = '0;
                sc_ovf_c    = 1'b0;
            end
            default: begin
            end
        endcase
    end

    // Operand magnitudes and result sign for the iterative unit.
    always_comb begin
        b_zero_c     = (data_operandB == '0);
        start_iter_c = (ctrl_ALUopcode == OP_MUL) ||
                       ((ctrl_ALUopcode == OP_DIV) && !b_zero_c);
        mag_a_c      = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
        mag_b_c      = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;
        neg_c        = data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
        mul_ovf_c    = (iter_hi_c != {WIDTH{iter_result_c[WIDTH-1]}});
        div_ovf_c    = (a_q == MIN_VAL) && (b_q == '1);
    end

    mul_div_iter #(
        .WIDTH (WIDTH)
    ) u_iter (
        .clock     (clock),
        .reset     (reset),
        .load_i    (iter_load_c),
        .step_i    (iter_step_c),
        .is_div_i  (ctrl_ALUopcode == OP_DIV),
        .mag_a_i   (mag_a_c),
        .mag_b_i   (mag_b_c),
        .neg_i     (neg_c),
        .result_c  (iter_result_c),
        .prod_hi_c (iter_hi_c),
        .done_c    (iter_done_c)
    );

    // Next state, operand latch and output register updates.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        result_d    = result_q;
        ne_d        = ne_q;
        lt_d        = lt_q;
        ovf_d       = ovf_q;
        exc_d       = exc_q;
        rdy_d       = 1'b0;
        busy_d      = busy_q;
        iter_load_c = 1'b0;
        iter_step_c = 1'b0;
        case (state_q)
            IDLE: begin
                if (ctrl_start) begin
                    op_d = ctrl_ALUopcode;
                    a_d  = data_operandA;
                    b_d  = data_operandB;
                    if (start_iter_c) begin
                        state_d     = ITER;
                        busy_d      = 1'b1;
                        iter_load_c = 1'b1;
                    end else begin
                        result_d = sc_result_c;
                        ovf_d    = sc_ovf_c;
                        exc_d    = (ctrl_ALUopcode == OP_DIV);
                        ne_d     = (data_operandA != data_operandB);
                        lt_d     = ($signed(data_operandA) < $signed(data_operandB));
                        rdy_d    = 1'b1;
                    end
                end
            end
            ITER: begin
                iter_step_c = 1'b1;
                if (iter_done_c) begin
                    state_d  = IDLE;
                    busy_d   = 1'b0;
                    rdy_d    = 1'b1;
                    result_d = iter_result_c;
                    ovf_d    = (op_q == OP_DIV) ? div_ovf_c : mul_ovf_c;
                    exc_d    = 1'b0;
                    ne_d     = (a_q != b_q);
                    lt_d     = ($signed(a_q) < $signed(b_q));
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            ne_q     <= 1'b0;
            lt_q     <= 1'b0;
            ovf_q    <= 1'b0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
            ne_q     <= ne_d;
            lt_q     <= lt_d;
            ovf_q    <= ovf_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
            busy_q   <= busy_d;
        end
    end

    assign data_result    = result_q;
    assign isNotEqual     = ne_q;
    assign isLessThan     = lt_q;
    assign overflow       = ovf_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=32) against a 64-bit arithmetic reference model.
module tb_alu_mc;

    localparam int unsigned W  = 32;
    localparam int unsigned SW = 5;
    localparam logic [31:0] MIN = 32'h8000_0000;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          ctrl_start = 1'b0;
    logic [4:0]    ctrl_ALUopcode = '0;
    logic [SW-1:0] ctrl_shiftamt = '0;
    logic [W-1:0]  data_operandA = '0;
    logic [W-1:0]  data_operandB = '0;
    logic [W-1:0]  data_result;
    logic          isNotEqual, isLessThan, overflow, data_exception, data_resultRDY, busy;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    alu_mc #(.WIDTH(W), .SHW(SW)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_start     (ctrl_start),
        .ctrl_ALUopcode (ctrl_ALUopcode),
        .ctrl_shiftamt  (ctrl_shiftamt),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .isNotEqual     (isNotEqual),
        .isLessThan     (isLessThan),
        .overflow       (overflow),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Reference: plain 64-bit signed arithmetic; lat = edges from start edge to RDY.
    function automatic void model(input logic [4:0] op, input logic [4:0] sh,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic ov,
                                  output logic ex, output int lat);
        longint sa, sb, full;
        int lo;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ex = 1'b0; ov = 1'b0; lat = 0; full = 0;
        case (op)
            5'd1: begin
                full = sa - sb; r = full[31:0];
                lo = int'(full[31:0]); ov = (longint'(lo) != full);
            end
            5'd2: r = a & b;
            5'd3: r = a | b;
            5'd4: begin full = sa << sh; r = full[31:0]; end
            5'd5: begin full = sa >>> sh; r = full[31:0]; end
            5'd6: begin
                full = sa * sb; r = full[31:0];
                lo = int'(full[31:0]); ov = (longint'(lo) != full); lat = 32;
            end
            5'd7: begin
                if (b == 32'd0) begin
                    r = 32'd0; ex = 1'b1;
                end else begin
                    full = sa / sb; r = full[31:0]; lat = 32;
                    ov = (a == MIN) && (b == 32'hFFFF_FFFF);
                end
            end
            default: begin
                full = sa + sb; r = full[31:0];
                lo = int'(full[31:0]); ov = (longint'(lo) != full);
            end
        endcase
    endfunction

    // Drive one start, scramble inputs, then wait (bounded) for RDY.
    task automatic issue(input logic [4:0] op, input logic [4:0] sh,
                         input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int busy_cyc, output int overlap,
                         output bit timeout);
        bit done;
        ctrl_ALUopcode = op; ctrl_shiftamt = sh;
        data_operandA = a; data_operandB = b; ctrl_start = 1'b1;
        @(posedge clock); #1;
        ctrl_start = 1'b0;
        ctrl_ALUopcode = 5'($urandom); ctrl_shiftamt = 5'($urandom);
        data_operandA = $urandom; data_operandB = $urandom;
        lat = 0; busy_cyc = 0; overlap = 0; timeout = 1'b0; done = 1'b0;
        while (!done) begin
            if (busy === 1'b1) busy_cyc++;
            if (busy === 1'b1 && data_resultRDY === 1'b1) overlap++;
            if (data_resultRDY === 1'b1) begin
                done = 1'b1;
            end else if (lat >= 100) begin
                timeout = 1'b1; done = 1'b1;
            end else begin
                @(posedge clock); #1; lat++;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({data_result, isNotEqual, isLessThan, overflow, data_exception, data_resultRDY, busy} !== '0) begin
            errors++; $display("FAIL reset_outputs: got result=%h flags=%b, want all 0", data_result,
                               {isNotEqual, isLessThan, overflow, data_exception, data_resultRDY, busy});
        end
        @(negedge clock); reset = 1'b0;
        @(posedge clock); #1;
        checks++;
        if ({data_resultRDY, busy} !== 2'b00) begin
            errors++; $display("FAIL reset_release: got rdy/busy=%b, want 00", {data_resultRDY, busy});
        end
    endtask

    task automatic test_add_overflow();
        int lat, bc, ov; bit to;
        issue(5'd0, 5'd0, 32'h7FFF_FFFF, 32'd1, lat, bc, ov, to);
        checks++;
        if (to || lat != 0) begin errors++; $display("FAIL add_latency: got %0d edges, want 0", lat); end
        checks++;
        if (data_result !== 32'h8000_0000 || overflow !== 1'b1) begin
            errors++; $display("FAIL add_result: got %h ovf=%b, want 80000000 ovf=1", data_result, overflow);
        end
        checks++;
        if (bc != 0 || busy !== 1'b0) begin errors++; $display("FAIL add_busy: got %0d busy cycles, want 0", bc); end
        @(posedge clock); #1;
        checks++;
        if (data_resultRDY !== 1'b0 || data_result !== 32'h8000_0000) begin
            errors++; $display("FAIL add_pulse_hold: got rdy=%b result=%h, want rdy=0 result=80000000",
                               data_resultRDY, data_result);
        end
    endtask

    task automatic test_sub_sra();
        int lat, bc, ov; bit to;
        issue(5'd1, 5'd0, 32'd5, 32'd9, lat, bc, ov, to);
        checks++;
        if (data_result !== 32'hFFFF_FFFC || {isLessThan, isNotEqual, overflow} !== 3'b110) begin
            errors++; $display("FAIL sub_result: got %h lt/ne/ovf=%b, want fffffffc 110", data_result,
                               {isLessThan, isNotEqual, overflow});
        end
        issue(5'd5, 5'd4, MIN, 32'd0, lat, bc, ov, to);
        checks++;
        if (to || lat != 0 || data_result !== 32'hF800_0000 || overflow !== 1'b0) begin
            errors++; $display("FAIL sra_result: got %h ovf=%b lat=%0d, want f8000000 ovf=0 lat=0",
                               data_result, overflow, lat);
        end
    endtask

    task automatic test_mul();
        int lat, bc, ov; bit to;
        issue(5'd6, 5'd0, 32'hFFFF_FFF9, 32'd6, lat, bc, ov, to);
        checks++;
        if (to || lat != 32 || bc != 32 || ov != 0) begin
            errors++; $display("FAIL mul_timing: got lat=%0d busy=%0d overlap=%0d, want 32 32 0", lat, bc, ov);
        end
        checks++;
        if (data_result !== 32'hFFFF_FFD6 || overflow !== 1'b0) begin
            errors++; $display("FAIL mul_neg: got %h ovf=%b, want ffffffd6 ovf=0", data_result, overflow);
        end
        issue(5'd6, 5'd0, 32'h0001_0000, 32'h0001_0000, lat, bc, ov, to);
        checks++;
        if (data_result !== 32'd0 || overflow !== 1'b1) begin
            errors++; $display("FAIL mul_ovf: got %h ovf=%b, want 00000000 ovf=1", data_result, overflow);
        end
    endtask

    task automatic test_div();
        int lat, bc, ov; bit to;
        issue(5'd7, 5'd0, 32'hFFFF_FFF9, 32'd2, lat, bc, ov, to);
        checks++;
        if (to || lat != 32 || data_result !== 32'hFFFF_FFFD) begin
            errors++; $display("FAIL div_trunc: got %h lat=%0d, want fffffffd lat=32", data_result, lat);
        end
        issue(5'd7, 5'd0, MIN, 32'hFFFF_FFFF, lat, bc, ov, to);
        checks++;
        if (data_result !== MIN || overflow !== 1'b1 || data_exception !== 1'b0) begin
            errors++; $display("FAIL div_min: got %h ovf=%b exc=%b, want 80000000 1 0", data_result,
                               overflow, data_exception);
        end
        issue(5'd7, 5'd0, 32'd5, 32'd0, lat, bc, ov, to);
        checks++;
        if (to || lat != 0 || bc != 0 || data_result !== 32'd0 || data_exception !== 1'b1 || overflow !== 1'b0) begin
            errors++; $display("FAIL div_zero: got %h exc=%b ovf=%b lat=%0d busy=%0d, want 0 1 0 0 0",
                               data_result, data_exception, overflow, lat, bc);
        end
    endtask

    task automatic test_random();
        int lat, bc, ov, elat; bit to;
        logic [4:0] op, sh;
        logic [31:0] a, b, er;
        logic eo, ex, ene, elt;
        for (int i = 0; i < 40; i++) begin
            op = (i % 5 == 4) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(0, 7));
            sh = 5'($urandom);
            a = $urandom; b = $urandom;
            case ($urandom_range(0, 3))
                1: begin a = 32'($urandom_range(0, 40)) - 32'd20; b = 32'($urandom_range(0, 40)) - 32'd20; end
                2: b = 32'd0;
                3: begin a = ($urandom_range(0, 1) != 0) ? MIN : 32'h7FFF_FFFF; b = 32'hFFFF_FFFF; end
                default: begin end
            endcase
            model(op, sh, a, b, er, eo, ex, elat);
            ene = (a != b);
            elt = ($signed(a) < $signed(b));
            issue(op, sh, a, b, lat, bc, ov, to);
            checks++;
            if (to || lat != elat) begin
                errors++; $display("FAIL rand_latency[%0d] op=%0d: got %0d, want %0d", i, op, lat, elat);
            end
            checks++;
            if (bc != elat || ov != 0) begin
                errors++; $display("FAIL rand_busy[%0d] op=%0d: got busy=%0d overlap=%0d, want %0d 0", i, op, bc, ov, elat);
            end
            checks++;
            if ({data_result, overflow, data_exception, isNotEqual, isLessThan} !== {er, eo, ex, ene, elt}) begin
                errors++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h sh=%0d: got %h o/e/ne/lt=%b, want %h %b",
                                   i, op, a, b, sh, data_result,
                                   {overflow, data_exception, isNotEqual, isLessThan}, er, {eo, ex, ene, elt});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] op, sh;
        logic [31:0] a, b, er;
        logic eo, ex;
        int elat;
        for (int i = 0; i < 6; i++) begin
            op = 5'($urandom_range(0, 6));
            a = $urandom; b = $urandom; sh = 5'($urandom);
            if (op == 5'd6) begin op = 5'd7; b = 32'd0; end
            model(op, sh, a, b, er, eo, ex, elat);
            ctrl_ALUopcode = op; ctrl_shiftamt = sh;
            data_operandA = a; data_operandB = b; ctrl_start = 1'b1;
            @(posedge clock); #1;
            checks++;
            if (data_resultRDY !== 1'b1 || {data_result, overflow, data_exception} !== {er, eo, ex}) begin
                errors++; $display("FAIL b2b[%0d] op=%0d: got rdy=%b %h o/e=%b, want rdy=1 %h %b", i, op,
                                   data_resultRDY, data_result, {overflow, data_exception}, er, {eo, ex});
            end
        end
        ctrl_start = 1'b0;
        @(posedge clock); #1;
        checks++;
        if (data_resultRDY !== 1'b0) begin errors++; $display("FAIL b2b_stop: got rdy=%b, want 0", data_resultRDY); end
    endtask

    task automatic test_start_while_busy();
        int k, extra;
        ctrl_ALUopcode = 5'd6; data_operandA = 32'hFFFF_FFF9; data_operandB = 32'd6; ctrl_start = 1'b1;
        @(posedge clock); #1;
        ctrl_start = 1'b0;
        k = 0;
        while (data_resultRDY !== 1'b1 && k < 60) begin
            if (k == 9) begin
                ctrl_ALUopcode = 5'd0; data_operandA = 32'd1; data_operandB = 32'd2; ctrl_start = 1'b1;
            end else begin
                ctrl_start = 1'b0;
            end
            @(posedge clock); #1;
            k++;
        end
        ctrl_start = 1'b0;
        checks++;
        if (k != 32 || data_result !== 32'hFFFF_FFD6) begin
            errors++; $display("FAIL busy_ignore: got first rdy at %0d result=%h, want 32 ffffffd6", k, data_result);
        end
        // ADD issued in the RDY cycle.
        ctrl_ALUopcode = 5'd0; data_operandA = 32'd100; data_operandB = 32'd23; ctrl_start = 1'b1;
        @(posedge clock); #1;
        ctrl_start = 1'b0;
        checks++;
        if (data_resultRDY !== 1'b1 || data_result !== 32'd123 || busy !== 1'b0) begin
            errors++; $display("FAIL rdy_cycle_add: got rdy=%b result=%h busy=%b, want 1 0000007b 0",
                               data_resultRDY, data_result, busy);
        end
        extra = 0;
        repeat (5) begin
            @(posedge clock); #1;
            if (data_resultRDY === 1'b1) extra++;
        end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL no_queue: got %0d extra rdy pulses, want 0", extra); end
    endtask

    task automatic test_reset_mid();
        int rdys, lat, bc, ov; bit to;
        ctrl_ALUopcode = 5'd7; data_operandA = 32'd1000; data_operandB = 32'd7; ctrl_start = 1'b1;
        @(posedge clock); #1;
        ctrl_start = 1'b0;
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({data_result, isNotEqual, isLessThan, overflow, data_exception, data_resultRDY, busy} !== '0) begin
            errors++; $display("FAIL reset_mid: got result=%h flags=%b, want all 0", data_result,
                               {isNotEqual, isLessThan, overflow, data_exception, data_resultRDY, busy});
        end
        @(posedge clock);
        @(negedge clock); reset = 1'b0;
        rdys = 0;
        repeat (40) begin
            @(posedge clock); #1;
            if (data_resultRDY === 1'b1 || busy === 1'b1) rdys++;
        end
        checks++;
        if (rdys != 0) begin errors++; $display("FAIL reset_abort: got %0d rdy/busy cycles, want 0", rdys); end
        issue(5'd0, 5'd0, 32'd3, 32'd4, lat, bc, ov, to);
        checks++;
        if (to || lat != 0 || data_result !== 32'd7) begin
            errors++; $display("FAIL post_reset_add: got %h lat=%0d, want 00000007 lat=0", data_result, lat);
        end
    endtask

    initial begin
        test_reset();
        test_add_overflow();
        test_sub_sra();
        test_mul();
        test_div();
        test_random();
        test_back_to_back();
        test_start_while_busy();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
